// File: rtl/branch_unit.sv
// RV32I conditional-branch resolution for the execute stage.
// Gives a combinational taken flag, plus a one-cycle registered copy of the
// decision, the branch target and the illegal-funct3 flag for redirect logic.
module branch_unit #(
  parameter int unsigned XLEN          = 32,
  parameter logic [4:0]  BRANCH_OPCODE = 5'b11000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [4:0]      opcode_6_to_2_in,
  input  logic [2:0]      funct3_in,
  input  logic [XLEN-1:0] rs1_in,
  input  logic [XLEN-1:0] rs2_in,
  input  logic [XLEN-1:0] pc_in,
  input  logic [XLEN-1:0] imm_in,
  input  logic            valid_in,
  output logic            branch_taken_out,
  output logic            branch_taken_q,
  output logic [XLEN-1:0] target_q,
  output logic            illegal_funct3_q,
  output logic            valid_q
);

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  logic            is_branch;
  logic            is_illegal;
  logic            eq;
  logic            lt_s;
  logic            lt_u;
  logic [XLEN-1:0] target;

  // Operand compare and opcode/funct3 decode; unused funct3 codes resolve to not-taken.
  always_comb begin
    is_branch        = (opcode_6_to_2_in == BRANCH_OPCODE);
    eq               = (rs1_in == rs2_in);
    lt_s             = ($signed(rs1_in) < $signed(rs2_in));
    lt_u             = (rs1_in < rs2_in);
    is_illegal       = is_branch && (funct3_in[2:1] == 2'b01);
    branch_taken_out = 1'b0;
    if (is_branch) begin
      case (funct3_in)
        F3_BEQ:  branch_taken_out = eq;
        F3_BNE:  branch_taken_out = !eq;
        F3_BLT:  branch_taken_out = lt_s;
        F3_BGE:  branch_taken_out = !lt_s;
        F3_BLTU: branch_taken_out = lt_u;
        F3_BGEU: branch_taken_out = !lt_u;
        default: branch_taken_out = 1'b0;
      endcase
    end
  end

  // Target wraps modulo 2^XLEN.
  assign target = pc_in + imm_in;

  // Registered result stage; target holds across invalid cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q          <= 1'b0;
      branch_taken_q   <= 1'b0;
      illegal_funct3_q <= 1'b0;
      target_q         <= '0;
    end else begin
      valid_q          <= valid_in;
      branch_taken_q   <= valid_in & branch_taken_out;
      illegal_funct3_q <= valid_in & is_illegal;
      if (valid_in) begin
        target_q <= target;
      end
    end
  end

endmodule

// File: tb/tb_branch_unit.sv
// Directed bench for branch_unit with a scoreboard for the registered outputs.
module tb_branch_unit;

  localparam int unsigned XLEN = 32;
  localparam logic [4:0]  OP_BR = 5'b11000;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [4:0]      opcode;
  logic [2:0]      funct3;
  logic [XLEN-1:0] rs1, rs2, pc, imm;
  logic            valid_in;
  logic            branch_taken_out, branch_taken_q, illegal_funct3_q, valid_q;
  logic [XLEN-1:0] target_q;

  typedef struct {
    logic            taken;
    logic [XLEN-1:0] target;
    logic            illegal;
    logic            valid;
  } exp_t;

  exp_t            sb[$];
  logic [XLEN-1:0] model_target;
  int              checks = 0;
  int              errors = 0;

  branch_unit #(.XLEN(XLEN), .BRANCH_OPCODE(OP_BR)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .opcode_6_to_2_in (opcode),
    .funct3_in        (funct3),
    .rs1_in           (rs1),
    .rs2_in           (rs2),
    .pc_in            (pc),
    .imm_in           (imm),
    .valid_in         (valid_in),
    .branch_taken_out (branch_taken_out),
    .branch_taken_q   (branch_taken_q),
    .target_q         (target_q),
    .illegal_funct3_q (illegal_funct3_q),
    .valid_q          (valid_q)
  );

  always #5 clk = ~clk;

  // Reference branch decision written straight from the ISA definition.
  function automatic logic ref_taken(input logic [4:0] op, input logic [2:0] f3,
                                     input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    logic signed [XLEN-1:0] sa, sb_;
    sa  = a;
    sb_ = b;
    if (op != OP_BR) return 1'b0;
    case (f3)
      3'b000:  return a == b;
      3'b001:  return a != b;
      3'b100:  return sa < sb_;
      3'b101:  return sa >= sb_;
      3'b110:  return a < b;
      3'b111:  return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_q_zero(input string tag);
    chk({tag, "_valid_q"},   XLEN'(valid_q), '0);
    chk({tag, "_taken_q"},   XLEN'(branch_taken_q), '0);
    chk({tag, "_illegal_q"}, XLEN'(illegal_funct3_q), '0);
    chk({tag, "_target_q"},  target_q, '0);
  endtask

  // Drive one instruction, check the combinational flag, then the registered result.
  task automatic step(input string tag, input logic [4:0] op, input logic [2:0] f3,
                      input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                      input logic [XLEN-1:0] p, input logic [XLEN-1:0] i,
                      input logic v, input logic exp_comb);
    exp_t e, got;
    @(negedge clk);
    opcode = op; funct3 = f3; rs1 = a; rs2 = b; pc = p; imm = i; valid_in = v;
    #1;
    chk({tag, "_comb"}, XLEN'(branch_taken_out), XLEN'(exp_comb));
    if (v) model_target = p + i;
    e.valid   = v;
    e.taken   = v & exp_comb;
    e.illegal = v && (op == OP_BR) && (f3[2:1] == 2'b01);
    e.target  = model_target;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      got = sb.pop_front();
      chk({tag, "_valid_q"},   XLEN'(valid_q), XLEN'(got.valid));
      chk({tag, "_taken_q"},   XLEN'(branch_taken_q), XLEN'(got.taken));
      chk({tag, "_illegal_q"}, XLEN'(illegal_funct3_q), XLEN'(got.illegal));
      chk({tag, "_target_q"},  target_q, got.target);
    end
  endtask

  initial begin
    rst_n = 1'b0; opcode = '0; funct3 = '0; rs1 = '0; rs2 = '0;
    pc = '0; imm = '0; valid_in = 1'b0; model_target = '0;
    #12;
    chk_q_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    step("beq_eq",   OP_BR, 3'b000, 32'h1, 32'h1, 32'h1000, 32'h8, 1'b1, 1'b1);
    step("beq_ne",   OP_BR, 3'b000, 32'h1, 32'h2, 32'h1004, 32'h8, 1'b1, 1'b0);
    step("bne_ne",   OP_BR, 3'b001, 32'h1, 32'h2, 32'h1008, 32'hFFFFFFF8, 1'b1, 1'b1);
    step("bne_eq",   OP_BR, 3'b001, 32'h5, 32'h5, 32'h100C, 32'h10, 1'b1, 1'b0);
    step("blt_neg",  OP_BR, 3'b100, 32'hFFFFFFFE, 32'h2, 32'h2000, 32'h4, 1'b1, 1'b1);
    step("bge_neg",  OP_BR, 3'b101, 32'hFFFFFFFE, 32'h1, 32'h2004, 32'h4, 1'b1, 1'b0);
    step("bge_min",  OP_BR, 3'b101, 32'h80000000, 32'h80000000, 32'h2008, 32'h4, 1'b1, 1'b1);
    step("bltu",     OP_BR, 3'b110, 32'h1, 32'hFFFFFFFF, 32'h3000, 32'h20, 1'b1, 1'b1);
    step("bgeu_lt",  OP_BR, 3'b111, 32'h1, 32'hFFFFFFFF, 32'h3004, 32'h20, 1'b1, 1'b0);
    step("bgeu_ge",  OP_BR, 3'b111, 32'hFFFFFFFF, 32'h1, 32'h3008, 32'h20, 1'b1, 1'b1);
    step("non_br",   5'b00011, 3'b000, 32'h7, 32'h7, 32'h4000, 32'h40, 1'b1, 1'b0);
    step("ill_010",  OP_BR, 3'b010, 32'h7, 32'h7, 32'h4004, 32'h40, 1'b1, 1'b0);
    step("ill_011",  OP_BR, 3'b011, 32'h3, 32'h9, 32'h4008, 32'h40, 1'b1, 1'b0);
    step("inv_hold", OP_BR, 3'b000, 32'h3, 32'h3, 32'h5000, 32'h40, 1'b0, 1'b1);
    step("inv_ill",  OP_BR, 3'b010, 32'h3, 32'h3, 32'h5004, 32'h40, 1'b0, 1'b0);
    step("wrap",     OP_BR, 3'b000, 32'h1, 32'h1, 32'hFFFFFFF0, 32'h20, 1'b1, 1'b1);

    // Compact randomized sweep against the reference function.
    for (int n = 0; n < 40; n++) begin
      logic [2:0]      f3;
      logic [XLEN-1:0] a, b;
      f3 = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = (n % 4 == 0) ? a : XLEN'($urandom);
      step("rand", OP_BR, f3, a, b, XLEN'($urandom), XLEN'($urandom), 1'($urandom_range(0, 1)),
           ref_taken(OP_BR, f3, a, b));
    end

    // Asynchronous reset between edges clears the registered outputs immediately.
    step("pre_rst", OP_BR, 3'b000, 32'h9, 32'h9, 32'h6000, 32'h100, 1'b1, 1'b1);
    @(negedge clk);
    opcode = OP_BR; funct3 = 3'b000; rs1 = 32'h4; rs2 = 32'h4; valid_in = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    chk_q_zero("async_rst");
    chk("async_rst_comb", XLEN'(branch_taken_out), XLEN'(1'b1));
    rs2 = 32'h5;
    #1;
    chk("async_rst_comb_track", XLEN'(branch_taken_out), XLEN'(1'b0));
    @(posedge clk);
    #1;
    chk_q_zero("rst_hold");
    sb.delete();
    model_target = '0;
    @(negedge clk);
    rst_n = 1'b1;
    step("post_rst", OP_BR, 3'b100, 32'h80000000, 32'h0, 32'h7000, 32'hFFFFF000, 1'b1, 1'b1);
    step("post_inv", OP_BR, 3'b001, 32'h1, 32'h2, 32'h7100, 32'h4, 1'b0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
